subleq_datapath: RTL and testbench

- Execution datapath for the SUBLEQ core; consumes the controller's `control_word` each cycle.
- Holds PC and operand registers and drives the single memory port.
- Computes B - A, decides branch and produces the `halt` signal fed back to the controller.
- Memory is an external single-port RAM with combinational read and write-on-clock-edge; one memory access per state.

---
 rtl/subleq_datapath_pkg.sv | 16 +
 rtl/subleq_alu.sv | 16 +
 rtl/subleq_datapath.sv | 97 +++++++++
 tb/tb_subleq_datapath.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/subleq_datapath_pkg.sv
// rtl/subleq_datapath_pkg.sv - shared state codes for the SUBLEQ controller/datapath pair
package subleq_datapath_pkg;

    localparam int STATE_BITS = 3;

    typedef enum logic [STATE_BITS-1:0] {
        FETCH_A   = 3'd0,
        DEREF_A   = 3'd1,
        FETCH_B   = 3'd2,
        DEREF_B   = 3'd3,
        STORE_SUB = 3'd4,
        FETCH_C   = 3'd5,
        HALT      = 3'd6
    } state_e;

endpackage

// File: rtl/subleq_alu.sv
// rtl/subleq_alu.sv - wrapped B - A with two's-complement less-or-equal-zero flag
module subleq_alu #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             leq
);

    always_comb begin
        diff = b - a;
        leq  = (diff == '0) || diff[WIDTH-1];
    end

endmodule

// File: rtl/subleq_datapath.sv
// rtl/subleq_datapath.sv - SUBLEQ execution datapath: PC, operand registers, memory port
import subleq_datapath_pkg::*;

module subleq_datapath #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter logic [WIDTH-1:0] HALT_TARGET = '1
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic [STATE_BITS-1:0] control_word,
    output logic                  halt,
    output logic [WIDTH-1:0]      mem_addr,
    input  logic [WIDTH-1:0]      mem_rdata,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic                  mem_we,
    output logic [WIDTH-1:0]      pc,
    output logic                  halted
);

    state_e           state;
    logic [WIDTH-1:0] a_addr;
    logic [WIDTH-1:0] a_val;
    logic [WIDTH-1:0] b_addr;
    logic [WIDTH-1:0] b_val;
    logic             leq;
    logic [WIDTH-1:0] alu_diff;
    logic             alu_leq;
    logic [WIDTH-1:0] pc_p1;
    logic [WIDTH-1:0] pc_p2;
    logic [WIDTH-1:0] pc_p3;

    assign state = state_e'(control_word);
    assign pc_p1 = pc + WIDTH'(1);
    assign pc_p2 = pc + WIDTH'(2);
    assign pc_p3 = pc + WIDTH'(3);

    subleq_alu #(.WIDTH(WIDTH)) u_alu (
        .a    (a_val),
        .b    (b_val),
        .diff (alu_diff),
        .leq  (alu_leq)
    );

    assign mem_wdata = alu_diff;

    // Unknown codes fall into the default arm: address pc, no write, no halt.
    always_comb begin
        mem_addr = pc;
        mem_we   = 1'b0;
        halt     = 1'b0;
        case (state)
            FETCH_A:   mem_addr = pc;
            DEREF_A:   mem_addr = a_addr;
            FETCH_B:   mem_addr = pc_p1;
            DEREF_B:   mem_addr = b_addr;
            STORE_SUB: begin
                mem_addr = b_addr;
                mem_we   = ~areset;
            end
            FETCH_C: begin
                mem_addr = pc_p2;
                halt     = ~areset && leq && (mem_rdata == HALT_TARGET);
            end
            default:   mem_addr = pc;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            pc     <= RESET_PC;
            a_addr <= '0;
            a_val  <= '0;
            b_addr <= '0;
            b_val  <= '0;
            leq    <= 1'b0;
            halted <= 1'b0;
        end else begin
            case (state)
                FETCH_A:   a_addr <= mem_rdata;
                DEREF_A:   a_val  <= mem_rdata;
                FETCH_B:   b_addr <= mem_rdata;
                DEREF_B:   b_val  <= mem_rdata;
                STORE_SUB: leq    <= alu_leq;
                FETCH_C: begin
                    // A halting branch leaves pc on the final instruction for debug.
                    if (!halt) begin
                        pc <= leq ? mem_rdata : pc_p3;
                    end
                end
                HALT:      halted <= 1'b1;
                default:   ;
            endcase
        end
    end

endmodule

// File: tb/tb_subleq_datapath.sv
// tb/tb_subleq_datapath.sv - scoreboard bench for subleq_datapath with controller model and RAM
`timescale 1ns/1ps
import subleq_datapath_pkg::*;

module tb_subleq_datapath;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic                  clk;
    logic                  areset;
    logic [STATE_BITS-1:0] control_word;
    logic                  halt;
    logic [7:0]            mem_addr;
    logic [7:0]            mem_rdata;
    logic [7:0]            mem_wdata;
    logic                  mem_we;
    logic [7:0]            pc;
    logic                  halted;

    logic [7:0] mem [256];
    logic       force_aa;
    state_e     st;
    wr_t        exp_q[$];
    int         checks;
    int         errors;
    int         we_cnt;
    int         halt_cnt;

    subleq_datapath #(.WIDTH(8), .RESET_PC(8'h00), .HALT_TARGET(8'hFF)) dut (
        .clk          (clk),
        .areset       (areset),
        .control_word (control_word),
        .halt         (halt),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .pc           (pc),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = force_aa ? 8'hAA : mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: every write the DUT presents must match the next expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            #2;
            if (mem_we === 1'b1 && areset === 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected: got addr=%0h data=%0h expected no write", mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                        errors++;
                        $display("FAIL write: got addr=%0h data=%0h expected addr=%0h data=%0h",
                                 mem_addr, mem_wdata, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    // Entered and left at a falling edge.
    task automatic do_reset(input int n);
        areset       = 1'b1;
        st           = FETCH_A;
        control_word = st;
        repeat (n) @(negedge clk);
        areset = 1'b0;
        we_cnt   = 0;
        halt_cnt = 0;
    endtask

    // Controller model: one state per cycle, HALT after an asserted halt.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            control_word = st;
            #1;
            if (mem_we) we_cnt++;
            if (halt) halt_cnt++;
            case (st)
                FETCH_A:   st = DEREF_A;
                DEREF_A:   st = FETCH_B;
                FETCH_B:   st = DEREF_B;
                DEREF_B:   st = STORE_SUB;
                STORE_SUB: st = FETCH_C;
                FETCH_C:   st = halt ? HALT : FETCH_A;
                default:   st = HALT;
            endcase
            @(negedge clk);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        we_cnt   = 0;
        halt_cnt = 0;
        areset   = 1'b1;
        force_aa = 1'b1;
        control_word = STORE_SUB;
        clear_mem();

        // Reset with garbage read data and a write state on the bus
        repeat (3) @(negedge clk);
        #1;
        chk("reset_pc", pc, 8'h00);
        chk("reset_mem_we", mem_we, 0);
        chk("reset_halt", halt, 0);
        chk("reset_halted", halted, 0);
        @(negedge clk);
        force_aa = 1'b0;

        // Not taken: 7 - 5 = 2
        clear_mem();
        mem[0] = 8'h03; mem[1] = 8'h04; mem[2] = 8'h09; mem[3] = 8'h05; mem[4] = 8'h07;
        do_reset(1);
        exp_q.push_back('{addr: 8'h04, data: 8'h02});
        run(6);
        chk("nt_mem4", mem[4], 8'h02);
        chk("nt_pc", pc, 8'h03);
        chk("nt_we_cycles", we_cnt, 1);

        // Taken on zero result
        clear_mem();
        mem[0] = 8'h03; mem[1] = 8'h04; mem[2] = 8'h09; mem[3] = 8'h07; mem[4] = 8'h07;
        do_reset(1);
        exp_q.push_back('{addr: 8'h04, data: 8'h00});
        run(6);
        chk("tz_mem4", mem[4], 8'h00);
        chk("tz_pc", pc, 8'h09);

        // Halt via aliased operands branching to FF
        clear_mem();
        mem[0] = 8'h05; mem[1] = 8'h05; mem[2] = 8'hFF; mem[5] = 8'h33;
        do_reset(1);
        exp_q.push_back('{addr: 8'h05, data: 8'h00});
        run(6);
        chk("halt_cycles", halt_cnt, 1);
        chk("halt_pc", pc, 8'h00);
        chk("halt_halted_early", halted, 0);
        run(4);
        chk("halt_halted", halted, 1);
        chk("halt_pc_hold", pc, 8'h00);
        chk("halt_we_total", we_cnt, 1);
        chk("halt_cycles_total", halt_cnt, 1);

        // Branch to FE, then wrap pc+2/pc+3 and a sign-crossing subtraction
        clear_mem();
        mem[8'h00] = 8'h20; mem[8'h01] = 8'h20; mem[8'h02] = 8'hFE;
        mem[8'hFE] = 8'h10; mem[8'hFF] = 8'h11;
        mem[8'h10] = 8'h01; mem[8'h11] = 8'h80; mem[8'h20] = 8'h44;
        do_reset(1);
        exp_q.push_back('{addr: 8'h20, data: 8'h00});
        exp_q.push_back('{addr: 8'h11, data: 8'h7F});
        run(6);
        chk("wrap_pc_fe", pc, 8'hFE);
        run(6);
        chk("wrap_mem11", mem[8'h11], 8'h7F);
        chk("wrap_pc", pc, 8'h01);

        // Reset asserted in the middle of STORE_SUB
        clear_mem();
        mem[0] = 8'h03; mem[1] = 8'h04; mem[2] = 8'h09; mem[3] = 8'h05; mem[4] = 8'h07;
        do_reset(1);
        run(4);
        control_word = st;
        #1;
        chk("rs_we_before", mem_we, 1);
        areset = 1'b1;
        #0.5;
        chk("rs_we_dropped", mem_we, 0);
        @(negedge clk);
        chk("rs_mem4", mem[4], 8'h07);
        chk("rs_pc", pc, 8'h00);
        do_reset(1);
        exp_q.push_back('{addr: 8'h04, data: 8'h02});
        run(6);
        chk("rs_restart_mem4", mem[4], 8'h02);
        chk("rs_restart_pc", pc, 8'h03);

        @(negedge clk);
        chk("pending_writes", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
